// File: rtl/posit_layer_serializer.sv
// posit_layer_serializer
// Collects the end-of-window result posit of each upstream positron lane and
// re-serializes the completed set as one downstream window (sow_o on beat 0,
// eow_o on the last beat). Posit values pass through bit-exact.
// Optional build macro: POSIT_SERIALIZER_DOUBLE_BUF_EN selects a fill/drain
// bank pair so capture continues while the previous window drains.
module posit_layer_serializer #(
    parameter int unsigned POSIT_WIDTH = 4,
    parameter int unsigned NB_POSITRON = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NB_POSITRON-1:0]            rts_i,
    input  logic [NB_POSITRON-1:0]            eow_i,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
    output logic [NB_POSITRON-1:0]            rtr_o,
    input  logic                              rtr_i,
    output logic                              rts_o,
    output logic                              sow_o,
    output logic                              eow_o,
    output logic [POSIT_WIDTH-1:0]            posit_o
);

    localparam int unsigned IDX_WIDTH = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_POSITRON - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [NB_POSITRON-1:0] cap;
    logic                   accept;
    logic                   last_beat;

    // A lane is captured only on a valid end-of-window beat while it is ready
    assign cap       = rts_i & eow_i & rtr_o;
    assign accept    = (state_q == SEND) & rtr_i;
    assign last_beat = (idx_q == LAST_IDX);

    // Downstream handshake signals depend on registered state only
    assign rts_o = (state_q == SEND);
    assign sow_o = (state_q == SEND) & (idx_q == '0);
    assign eow_o = (state_q == SEND) & last_beat;

`ifdef POSIT_SERIALIZER_DOUBLE_BUF_EN

    logic [POSIT_WIDTH-1:0] bank_q [2][NB_POSITRON];
    logic [NB_POSITRON-1:0] mask_q [2];
    logic                   sel_q;      // index of the fill bank; drain bank is ~sel_q
    logic [NB_POSITRON-1:0] fill_mask;
    logic [NB_POSITRON-1:0] fill_mask_d;
    logic                   drain_idle;
    logic                   swap;

    assign fill_mask   = mask_q[sel_q];
    assign fill_mask_d = fill_mask | cap;
    assign rtr_o       = ~fill_mask;
    // Drain bank is free when idle or when its last beat leaves this cycle
    assign drain_idle  = (state_q == COLLECT) | (accept & last_beat);
    assign swap        = (&fill_mask_d) & drain_idle;

    assign posit_o = (state_q == SEND) ? bank_q[~sel_q][idx_q] : '0;

    // Capture into the fill bank, swap banks when full, step the drain index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                mask_q[b] <= '0;
                for (int unsigned k = 0; k < NB_POSITRON; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NB_POSITRON; k++) begin
                if (cap[k]) begin
                    bank_q[sel_q][k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                end
            end
            mask_q[sel_q] <= fill_mask_d;
            if (swap) begin
                // Full fill bank becomes the drain bank; old drain bank refills
                sel_q          <= ~sel_q;
                mask_q[~sel_q] <= '0;
                state_q        <= SEND;
                idx_q          <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    state_q <= COLLECT;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

`else

    logic [POSIT_WIDTH-1:0] bank_q [NB_POSITRON];
    logic [NB_POSITRON-1:0] mask_q;
    logic [NB_POSITRON-1:0] mask_d;

    assign rtr_o  = (state_q == COLLECT) ? ~mask_q : '0;
    assign mask_d = mask_q | cap;

    assign posit_o = (state_q == SEND) ? bank_q[idx_q] : '0;

    // Collect lanes until the mask is full, then drain the bank beat by beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            mask_q  <= '0;
            for (int unsigned k = 0; k < NB_POSITRON; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NB_POSITRON; k++) begin
                if (cap[k]) begin
                    bank_q[k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                end
            end
            case (state_q)
                COLLECT: begin
                    mask_q <= mask_d;
                    if (&mask_d) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (last_beat) begin
                            idx_q   <= '0;
                            mask_q  <= '0;
                            state_q <= COLLECT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`endif

endmodule
